muldiv_ctrl: RTL and testbench

Sequencer for the EX-stage multiply/divide resources. It accepts one MULT/MULTU/DIV/DIVU operation from EX and latches the operands. It then drives either the pipelined multiplier or the iterative divider, and holds `stallreq` until the 64-bit result is captured. It emits exactly one HI/LO commit per operation and handles flush, divide-by-zero and EX back-pressure.

---
 rtl/muldiv_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the EX stage.
// Accepts one MULT/MULTU/DIV/DIVU from EX, drives the pipelined multiplier or
// the iterative divider, stalls the front of the pipe until the 64-bit result
// is captured, then issues a single HI/LO commit pulse.
module muldiv_ctrl #(
  parameter int MUL_LAT = 1  // multiplier latency in cycles, 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_hold,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(MUL_LAT);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_sgn;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_first;      // high during the first DONE cycle only

  logic        w_any_op;
  logic        w_is_div;
  logic        w_sgn;
  logic        w_accept;
  logic        w_cap;
  logic [31:0] w_cap_hi;
  logic [31:0] w_cap_lo;

  // Decode: divide wins over multiply, signed wins over unsigned within each.
  assign w_any_op = op_mult | op_multu | op_div | op_divu;
  assign w_is_div = op_div | op_divu;
  assign w_sgn    = op_div | (~op_divu & op_mult);
  assign w_accept = (r_state == S_IDLE) & w_any_op & ~flush;

  assign stallreq = w_accept | (r_state == S_MUL_WAIT) | (r_state == S_DIV_RUN);
  assign busy     = (r_state != S_IDLE);

  // State register and multiplier latency counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Operand, signedness and result capture; first-DONE-cycle marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sgn   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_first <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opa <= src_a;
        r_opb <= src_b;
        r_sgn <= w_sgn;
      end
      if (w_cap) begin
        r_hi <= w_cap_hi;
        r_lo <= w_cap_lo;
      end
      r_first <= (w_next == S_DONE) && (r_state != S_DONE);
    end
  end

  // Next-state, result capture and resource/commit outputs.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_cap      = 1'b0;
    w_cap_hi   = '0;
    w_cap_lo   = '0;
    mul_signed = 1'b0;
    mul_ina    = '0;
    mul_inb    = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_opa    = '0;
    div_opb    = '0;
    div_annul  = 1'b0;
    hilo_we    = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_div) begin
            if (src_b == 32'd0) begin
              // Divide by zero: skip the divider and commit {0,0}.
              w_next = S_DONE;
              w_cap  = 1'b1;
            end else begin
              w_next = S_DIV_RUN;
            end
          end else begin
            w_next     = S_MUL_WAIT;
            w_cnt_next = LAT;
          end
        end
      end
      S_MUL_WAIT: begin
        mul_signed = r_sgn;
        mul_ina    = r_opa;
        mul_inb    = r_opb;
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_cap    = 1'b1;
          w_cap_hi = mul_result[63:32];
          w_cap_lo = mul_result[31:0];
          w_next   = S_DONE;
        end
      end
      S_DIV_RUN: begin
        div_signed = r_sgn;
        div_opa    = r_opa;
        div_opb    = r_opb;
        div_start  = ~div_ready;
        if (div_ready) begin
          w_cap    = 1'b1;
          w_cap_hi = div_result[63:32];
          w_cap_lo = div_result[31:0];
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        hilo_we  = r_first;
        hi_wdata = r_hi;
        lo_wdata = r_lo;
        if (!ex_hold) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Flush abandons the operation from any state and drops any result.
    if (flush) begin
      w_next     = S_IDLE;
      w_cnt_next = '0;
      w_cap      = 1'b0;
      hilo_we    = 1'b0;
      div_annul  = (r_state == S_DIV_RUN);
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. Models the multiplier as a product
// delayed by MUL_LAT-1 stages and the divider as a unit answering after a
// programmable number of div_start cycles; expectations come from plain
// arithmetic on the operands and the operation priority rules.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 1;
  localparam logic [3:0] OP_DIV   = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MULT  = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0001;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_hold;
  logic        op_mult, op_multu, op_div, op_divu;
  logic [31:0] src_a, src_b;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opa, div_opb;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stallreq, hilo_we, busy;
  logic [31:0] hi_wdata, lo_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .src_a(src_a), .src_b(src_b),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_opa(div_opa), .div_opb(div_opb), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; quotient truncates toward zero.
  function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic sgn);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = int'(a);
      sb = int'(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // ---------------- multiplier model ----------------
  localparam int PIX = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  logic [63:0] w_prod;
  logic [63:0] prod_q [1:7];
  assign w_prod = ref_mul(mul_ina, mul_inb, mul_signed);
  always @(posedge clk) begin
    prod_q[1] <= w_prod;
    for (int i = 2; i <= 7; i++) prod_q[i] <= prod_q[i-1];
  end
  assign mul_result = (MUL_LAT == 1) ? w_prod : prod_q[PIX];

  // ---------------- divider model ----------------
  int div_lat = 32;
  int dcnt    = 0;
  always @(posedge clk) begin
    if (rst || div_annul || div_ready) dcnt <= 0;
    else if (div_start)                dcnt <= dcnt + 1;
  end
  assign div_ready  = (div_lat > 0) && (dcnt == div_lat);
  assign div_result = ref_div(div_opa, div_opb, div_signed);

  // ---------------- helpers ----------------
  task automatic clear_inputs;
    flush = 0; ex_hold = 0;
    op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
    src_a = 0; src_b = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Issues one operation, holds ex_hold for `hold` DONE cycles, and returns
  // what was observed. Ends at the cycle after DONE exits (inputs idle).
  task automatic run_op(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                        input int hold,
                        output int n_stall, output int n_commit, output int n_dstart,
                        output int n_done, output logic [31:0] hi, output logic [31:0] lo,
                        output logic sgn_seen, output logic ended, output logic idle_after);
    logic leaving;
    n_stall = 0; n_commit = 0; n_dstart = 0; n_done = 0;
    hi = 0; lo = 0; sgn_seen = 0; ended = 0; leaving = 0;
    @(negedge clk);
    {op_div, op_divu, op_mult, op_multu} = ops;
    src_a = a; src_b = b; ex_hold = 0; flush = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (stallreq) n_stall++;
      if (div_start) n_dstart++;
      if (mul_signed || div_signed) sgn_seen = 1;
      if (hilo_we) begin n_commit++; hi = hi_wdata; lo = lo_wdata; end
      if (busy && !stallreq) begin
        n_done++;
        ex_hold = (n_done <= hold);
        leaving = !ex_hold;
      end
      @(negedge clk);
      if (leaving) begin ended = 1; break; end
    end
    clear_inputs();
    #1;
    idle_after = !busy && !stallreq;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset();
    #1;
    n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    n_checks++; if (hilo_we !== 1'b0) begin n_fail++; $display("FAIL reset_hilo_we: got %b want 0", hilo_we); end
    n_checks++; if ({hi_wdata, lo_wdata} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo_data: got %h want 0", {hi_wdata, lo_wdata}); end
    n_checks++; if ({div_start, div_annul, div_signed, div_opa, div_opb} !== 67'd0) begin n_fail++; $display("FAIL reset_div_outs: got %h want 0", {div_start, div_annul, div_signed, div_opa, div_opb}); end
    n_checks++; if ({mul_signed, mul_ina, mul_inb} !== 65'd0) begin n_fail++; $display("FAIL reset_mul_outs: got %h want 0", {mul_signed, mul_ina, mul_inb}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_mult_signed;
    int ns, nc, nd, ndone; logic [31:0] hi, lo; logic sg, en, id;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, ns, nc, nd, ndone, hi, lo, sg, en, id);
    n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL mult_timeout: got %b want 1", en); end
    n_checks++; if (ns !== MUL_LAT + 1) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d want %0d", ns, MUL_LAT + 1); end
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL mult_commits: got %0d want 1", nc); end
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mult_result: got %h want ffffffff_fffffff1", {hi, lo}); end
    n_checks++; if (sg !== 1'b1) begin n_fail++; $display("FAIL mult_signed_sel: got %b want 1", sg); end
    n_checks++; if (id !== 1'b1) begin n_fail++; $display("FAIL mult_idle_after: got %b want 1", id); end
  endtask

  task automatic test_multu;
    int ns, nc, nd, ndone; logic [31:0] hi, lo; logic sg, en, id;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, ns, nc, nd, ndone, hi, lo, sg, en, id);
    n_checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_result: got %h want 00000001_fffffffe", {hi, lo}); end
    n_checks++; if (sg !== 1'b0) begin n_fail++; $display("FAIL multu_signed_sel: got %b want 0", sg); end
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL multu_commits: got %0d want 1", nc); end
  endtask

  task automatic test_div;
    int ns, nc, nd, ndone; logic [31:0] hi, lo; logic sg, en, id;
    div_lat = 32;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, ns, nc, nd, ndone, hi, lo, sg, en, id);
    n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL div_timeout: got %b want 1", en); end
    n_checks++; if (nd !== 32) begin n_fail++; $display("FAIL div_start_cycles: got %0d want 32", nd); end
    n_checks++; if (ns !== 34) begin n_fail++; $display("FAIL div_stall_cycles: got %0d want 34", ns); end
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_result: got %h want ffffffff_fffffffd", {hi, lo}); end
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL div_commits: got %0d want 1", nc); end
  endtask

  task automatic test_divu_zero;
    int ns, nc, nd, ndone; logic [31:0] hi, lo; logic sg, en, id;
    run_op(OP_DIVU, 32'd10, 32'd0, 0, ns, nc, nd, ndone, hi, lo, sg, en, id);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL divz_start_cycles: got %0d want 0", nd); end
    n_checks++; if (ns !== 1) begin n_fail++; $display("FAIL divz_stall_cycles: got %0d want 1", ns); end
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL divz_commits: got %0d want 1", nc); end
    n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL divz_result: got %h want 0", {hi, lo}); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL divz_done_cycles: got %0d want 1", ndone); end
  endtask

  // Flush in DIV_RUN cycle 10; lat selects whether div_ready coincides.
  task automatic flush_div_at10(input int lat, input string tag);
    int n_annul, n_we;
    n_annul = 0; n_we = 0;
    div_lat = lat;
    @(negedge clk);
    op_div = 1; src_a = 32'd100; src_b = 32'd7;
    #1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) begin flush = 1; op_div = 0; end
      #1;
      if (div_annul) n_annul++;
      if (hilo_we) n_we++;
    end
    @(negedge clk);
    flush = 0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after_flush: busy got %b want 0", tag, busy); end
    for (int k = 0; k < 3; k++) begin
      if (hilo_we) n_we++;
      if (div_annul) n_annul++;
      @(negedge clk); #1;
    end
    n_checks++; if (n_annul !== 1) begin n_fail++; $display("FAIL %s_annul_cycles: got %0d want 1", tag, n_annul); end
    n_checks++; if (n_we !== 0) begin n_fail++; $display("FAIL %s_commits: got %0d want 0", tag, n_we); end
    clear_inputs();
  endtask

  task automatic test_flush_div;
    int ns, nc, nd, ndone; logic [31:0] hi, lo; logic sg, en, id;
    flush_div_at10(32, "flush");
    flush_div_at10(9, "flush_ready");
    run_op(OP_MULT, 32'd3, 32'd4, 0, ns, nc, nd, ndone, hi, lo, sg, en, id);
    n_checks++; if ({hi, lo} !== 64'd12) begin n_fail++; $display("FAIL post_flush_mult: got %h want 12", {hi, lo}); end
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL post_flush_commits: got %0d want 1", nc); end
  endtask

  task automatic test_ex_hold;
    int ns, nc, nd, ndone; logic [31:0] a, b, hi, lo; logic sg, en, id;
    logic [63:0] exp;
    a = $urandom; b = $urandom;
    exp = ref_mul(a, b, 1'b1);
    run_op(OP_MULT, a, b, 3, ns, nc, nd, ndone, hi, lo, sg, en, id);
    n_checks++; if (nc !== 1) begin n_fail++; $display("FAIL hold_commits: got %0d want 1", nc); end
    n_checks++; if (ndone !== 4) begin n_fail++; $display("FAIL hold_done_cycles: got %0d want 4", ndone); end
    n_checks++; if (ns !== MUL_LAT + 1) begin n_fail++; $display("FAIL hold_stall_cycles: got %0d want %0d", ns, MUL_LAT + 1); end
    n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL hold_result: got %h want %h", {hi, lo}, exp); end
    n_checks++; if (id !== 1'b1) begin n_fail++; $display("FAIL hold_idle_after: got %b want 1", id); end
  endtask

  task automatic test_back_to_back;
    int cyc; int commits; logic [31:0] lo2;
    commits = 0; lo2 = 0;
    @(negedge clk);
    op_mult = 1; src_a = 32'd6; src_b = 32'd7;
    cyc = 0; #1;
    while (!(busy && !stallreq) && cyc < 50) begin @(negedge clk); #1; cyc++; end
    n_checks++; if ({hilo_we, lo_wdata} !== {1'b1, 32'd42}) begin n_fail++; $display("FAIL b2b_first: got we=%b lo=%0d want we=1 lo=42", hilo_we, lo_wdata); end
    @(negedge clk);
    src_a = 32'd5; src_b = 32'd9;
    #1;
    n_checks++; if ({stallreq, busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept: got stall/busy=%b want 10", {stallreq, busy}); end
    cyc = 0;
    while (commits == 0 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
      if (hilo_we) begin commits++; lo2 = lo_wdata; end
    end
    n_checks++; if (lo2 !== 32'd45) begin n_fail++; $display("FAIL b2b_second: got %0d want 45", lo2); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_rst_mid_div;
    div_lat = 32;
    @(negedge clk);
    op_div = 1; src_a = 32'd1000; src_b = 32'd3;
    repeat (6) @(negedge clk);
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++; if ({stallreq, hilo_we, hi_wdata, lo_wdata, busy} !== 67'd0) begin n_fail++; $display("FAIL rst_mid_div_ctrl: got %h want 0", {stallreq, hilo_we, hi_wdata, lo_wdata, busy}); end
    n_checks++; if ({div_start, div_annul, div_signed, div_opa, div_opb, mul_signed, mul_ina, mul_inb} !== 132'd0) begin n_fail++; $display("FAIL rst_mid_div_res: got nonzero resource outputs, want 0"); end
  endtask

  task automatic test_random;
    int ns, nc, nd, ndone, hold, lat; logic [31:0] a, b, hi, lo; logic sg, en, id;
    logic [3:0] ops; logic is_div, sgn; logic [63:0] exp;
    int exp_stall, exp_dstart;
    for (int it = 0; it < 24; it++) begin
      ops  = 4'($urandom_range(1, 15));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      hold = $urandom_range(0, 2);
      lat  = $urandom_range(1, 40);
      if (ops[3])      begin is_div = 1; sgn = 1; end
      else if (ops[2]) begin is_div = 1; sgn = 0; end
      else if (ops[1]) begin is_div = 0; sgn = 1; end
      else             begin is_div = 0; sgn = 0; end
      if (is_div && sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      div_lat = lat;
      if (is_div) begin
        exp        = ref_div(a, b, sgn);
        exp_stall  = (b == 0) ? 1 : lat + 2;
        exp_dstart = (b == 0) ? 0 : lat;
      end else begin
        exp        = ref_mul(a, b, sgn);
        exp_stall  = MUL_LAT + 1;
        exp_dstart = 0;
      end
      run_op(ops, a, b, hold, ns, nc, nd, ndone, hi, lo, sg, en, id);
      n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL rnd%0d_result ops=%b a=%h b=%h: got %h want %h", it, ops, a, b, {hi, lo}, exp); end
      n_checks++; if (ns !== exp_stall) begin n_fail++; $display("FAIL rnd%0d_stall ops=%b: got %0d want %0d", it, ops, ns, exp_stall); end
      n_checks++; if (nd !== exp_dstart) begin n_fail++; $display("FAIL rnd%0d_dstart ops=%b: got %0d want %0d", it, ops, nd, exp_dstart); end
      n_checks++; if ({nc, ndone} !== {32'd1, 32'(hold + 1)}) begin n_fail++; $display("FAIL rnd%0d_commit: got commits=%0d done=%0d want 1/%0d", it, nc, ndone, hold + 1); end
      n_checks++; if (sg !== (sgn && !(is_div && b == 0))) begin n_fail++; $display("FAIL rnd%0d_sign: got %b want %b", it, sg, sgn && !(is_div && b == 0)); end
      n_checks++; if ({en, id} !== 2'b11) begin n_fail++; $display("FAIL rnd%0d_end: got end/idle=%b want 11", it, {en, id}); end
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_divu_zero();
    test_flush_div();
    test_ex_hold();
    test_back_to_back();
    test_random();
    test_rst_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
